// File: rtl/agen_lsu_stage_if.sv
// Handshake and bus signals between the AGEN ALU, the agen_lsu_stage and the LSQ.
// The stage itself connects through the slave modport; the driving environment uses master.
interface agen_lsu_stage_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 5
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] address_i;
    logic [1:0]        ldstSize_i;
    logic              isLoad_i;
    logic              isStore_i;
    logic              isLR_i;
    logic              isSC_i;
    logic [TAG_W-1:0]  tag_i;
    logic              snoopValid_i;
    logic [DATA_W-1:0] snoopAddr_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] address_o;
    logic [1:0]        ldstSize_o;
    logic [TAG_W-1:0]  tag_o;
    logic              isLoad_o;
    logic              isStore_o;
    logic              isLR_o;
    logic              isSC_o;
    logic [7:0]        byteEn_o;
    logic              misaligned_o;
    logic              scFail_o;
    logic              resValid_o;

    modport master (
        output flush_i, valid_i, address_i, ldstSize_i, isLoad_i, isStore_i, isLR_i, isSC_i,
               tag_i, snoopValid_i, snoopAddr_i, ready_i,
        input  ready_o, valid_o, address_o, ldstSize_o, tag_o, isLoad_o, isStore_o, isLR_o,
               isSC_o, byteEn_o, misaligned_o, scFail_o, resValid_o
    );

    modport slave (
        input  flush_i, valid_i, address_i, ldstSize_i, isLoad_i, isStore_i, isLR_i, isSC_i,
               tag_i, snoopValid_i, snoopAddr_i, ready_i,
        output ready_o, valid_o, address_o, ldstSize_o, tag_o, isLoad_o, isStore_o, isLR_o,
               isSC_o, byteEn_o, misaligned_o, scFail_o, resValid_o
    );
endinterface

// File: rtl/agen_lsu_stage.sv
// One-cycle register stage after AGEN: byte enables, misalignment check, and the hart's
// LR/SC reservation (granule, timeout, snoop kill) with SC pass/fail resolution.
module agen_lsu_stage #(
    parameter int DATA_W       = 64,
    parameter int TAG_W        = 5,
    parameter int RES_GRAN_LOG = 3,
    parameter int RES_TIMEOUT  = 64
) (
    input logic             clk,
    input logic             reset,
    agen_lsu_stage_if.slave bus
);
    localparam int GRAN_W = DATA_W - RES_GRAN_LOG;
    localparam int CNT_W  = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_TIMEOUT - 1);

    typedef enum logic {
        RES_IDLE = 1'b0,
        RES_HELD = 1'b1
    } res_state_t;

    res_state_t        res_state;
    logic [GRAN_W-1:0] res_addr;
    logic [CNT_W-1:0]  res_cnt;

    logic       accept;
    logic       held;
    logic       snoop_hit;
    logic       timeout;
    logic       gran_match;
    logic       sc_fail;
    logic       misaligned;
    logic [7:0] size_mask;
    logic [7:0] byte_en;
    logic       unused_snoop_low;

    assign bus.ready_o = !bus.valid_o || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o && !bus.flush_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
        case (bus.ldstSize_i)
            2'd0: begin size_mask = 8'h01; misaligned = 1'b0;                 end
            2'd1: begin size_mask = 8'h03; misaligned = bus.address_i[0];     end
            2'd2: begin size_mask = 8'h0F; misaligned = |bus.address_i[1:0]; end
            default: begin size_mask = 8'hFF; misaligned = |bus.address_i[2:0]; end
        endcase
        byte_en = misaligned ? 8'h00 : (size_mask << bus.address_i[2:0]);
    end

    assign held       = (res_state == RES_HELD);
    assign snoop_hit  = held && bus.snoopValid_i
                        && (bus.snoopAddr_i[DATA_W-1:RES_GRAN_LOG] == res_addr);
    assign timeout    = held && (res_cnt == CNT_LAST);
    assign gran_match = (bus.address_i[DATA_W-1:RES_GRAN_LOG] == res_addr);
    // A same-cycle snoop hit or timeout already counts as a lost reservation for the SC.
    assign sc_fail    = misaligned || !(held && !snoop_hit && !timeout && gran_match);

    assign unused_snoop_low = ^bus.snoopAddr_i[RES_GRAN_LOG-1:0];
    assign bus.resValid_o   = held;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_state <= RES_IDLE;
            res_addr  <= '0;
            res_cnt   <= '0;
        end else if (bus.flush_i) begin
            res_state <= RES_IDLE;
            res_cnt   <= '0;
        end else if (accept && bus.isLR_i && !misaligned) begin
            res_state <= RES_HELD;
            res_addr  <= bus.address_i[DATA_W-1:RES_GRAN_LOG];
            res_cnt   <= '0;
        end else if (accept && bus.isSC_i && !misaligned) begin
            res_state <= RES_IDLE;
            res_cnt   <= '0;
        end else if (snoop_hit || timeout) begin
            res_state <= RES_IDLE;
            res_cnt   <= '0;
        end else if (held) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.valid_o      <= 1'b0;
            bus.address_o    <= '0;
            bus.ldstSize_o   <= 2'd0;
            bus.tag_o        <= '0;
            bus.isLoad_o     <= 1'b0;
            bus.isStore_o    <= 1'b0;
            bus.isLR_o       <= 1'b0;
            bus.isSC_o       <= 1'b0;
            bus.byteEn_o     <= 8'h00;
            bus.misaligned_o <= 1'b0;
            bus.scFail_o     <= 1'b0;
        end else if (bus.flush_i) begin
            bus.valid_o <= 1'b0;
        end else if (accept) begin
            bus.valid_o      <= 1'b1;
            bus.address_o    <= bus.address_i;
            bus.ldstSize_o   <= bus.ldstSize_i;
            bus.tag_o        <= bus.tag_i;
            bus.isLoad_o     <= bus.isLoad_i;
            bus.isStore_o    <= bus.isStore_i;
            bus.isLR_o       <= bus.isLR_i;
            bus.isSC_o       <= bus.isSC_i;
            bus.byteEn_o     <= byte_en;
            bus.misaligned_o <= misaligned;
            bus.scFail_o     <= bus.isSC_i && sc_fail;
        end else if (bus.ready_i) begin
            bus.valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_agen_lsu_stage.sv
// Directed bench for agen_lsu_stage: alignment, LR/SC, snoop, timeout, backpressure, flush, reset.
module tb_agen_lsu_stage;
    localparam logic [3:0] OP_LD = 4'b1000;
    localparam logic [3:0] OP_ST = 4'b0100;
    localparam logic [3:0] OP_LR = 4'b0010;
    localparam logic [3:0] OP_SC = 4'b0001;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    agen_lsu_stage_if #(.DATA_W(64), .TAG_W(5)) bus ();

    agen_lsu_stage #(.DATA_W(64), .TAG_W(5), .RES_GRAN_LOG(3), .RES_TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.valid_i      = 1'b0;
        bus.address_i    = '0;
        bus.ldstSize_i   = 2'd0;
        bus.isLoad_i     = 1'b0;
        bus.isStore_i    = 1'b0;
        bus.isLR_i       = 1'b0;
        bus.isSC_i       = 1'b0;
        bus.tag_i        = '0;
        bus.flush_i      = 1'b0;
        bus.snoopValid_i = 1'b0;
        bus.snoopAddr_i  = '0;
        bus.ready_i      = 1'b1;
    endtask

    task automatic op(input logic [63:0] a, input logic [1:0] sz, input logic [3:0] kind,
                      input logic [4:0] t);
        bus.valid_i    = 1'b1;
        bus.address_i  = a;
        bus.ldstSize_i = sz;
        bus.isLoad_i   = kind[3];
        bus.isStore_i  = kind[2];
        bus.isLR_i     = kind[1];
        bus.isSC_i     = kind[0];
        bus.tag_i      = t;
    endtask

    task automatic snoop(input logic [63:0] a);
        bus.snoopValid_i = 1'b1;
        bus.snoopAddr_i  = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset valid_o: got %b want 0", bus.valid_o); end
        checks++; if (bus.resValid_o !== 1'b0) begin errors++; $display("FAIL reset resValid_o: got %b want 0", bus.resValid_o); end
        checks++; if (bus.byteEn_o !== 8'h00) begin errors++; $display("FAIL reset byteEn_o: got %h want 00", bus.byteEn_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset ready_o: got %b want 1", bus.ready_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alignment();
        op(64'h1004, 2'd2, OP_LD, 5'd1); tick();
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL align_word valid_o: got %b want 1", bus.valid_o); end
        checks++; if (bus.byteEn_o !== 8'hF0) begin errors++; $display("FAIL align_word byteEn_o: got %h want f0", bus.byteEn_o); end
        checks++; if (bus.misaligned_o !== 1'b0) begin errors++; $display("FAIL align_word misaligned_o: got %b want 0", bus.misaligned_o); end
        checks++; if (bus.address_o !== 64'h1004 || bus.tag_o !== 5'd1 || bus.isLoad_o !== 1'b1) begin errors++; $display("FAIL align_word fields: got addr=%h tag=%0d ld=%b want 1004/1/1", bus.address_o, bus.tag_o, bus.isLoad_o); end
        checks++; if (bus.scFail_o !== 1'b0) begin errors++; $display("FAIL align_word scFail_o: got %b want 0", bus.scFail_o); end
        op(64'h1003, 2'd1, OP_ST, 5'd2); tick();
        checks++; if (bus.byteEn_o !== 8'h00) begin errors++; $display("FAIL align_half byteEn_o: got %h want 00", bus.byteEn_o); end
        checks++; if (bus.misaligned_o !== 1'b1) begin errors++; $display("FAIL align_half misaligned_o: got %b want 1", bus.misaligned_o); end
        checks++; if (bus.isStore_o !== 1'b1 || bus.ldstSize_o !== 2'd1) begin errors++; $display("FAIL align_half fields: got st=%b size=%0d want 1/1", bus.isStore_o, bus.ldstSize_o); end
        op(64'h2000, 2'd3, OP_LD, 5'd3); tick();
        checks++; if (bus.byteEn_o !== 8'hFF || bus.misaligned_o !== 1'b0) begin errors++; $display("FAIL align_double: got be=%h mis=%b want ff/0", bus.byteEn_o, bus.misaligned_o); end
        op(64'h0007, 2'd0, OP_ST, 5'd4); tick();
        checks++; if (bus.byteEn_o !== 8'h80 || bus.misaligned_o !== 1'b0) begin errors++; $display("FAIL align_byte7: got be=%h mis=%b want 80/0", bus.byteEn_o, bus.misaligned_o); end
        op(64'h100A, 2'd2, OP_LD, 5'd5); tick();
        checks++; if (bus.byteEn_o !== 8'h00 || bus.misaligned_o !== 1'b1) begin errors++; $display("FAIL align_word_a: got be=%h mis=%b want 00/1", bus.byteEn_o, bus.misaligned_o); end
        idle(); tick();
        checks++; if (bus.valid_o !== 1'b0 || bus.tag_o !== 5'd5) begin errors++; $display("FAIL drain: got valid=%b tag=%0d want 0/5", bus.valid_o, bus.tag_o); end
    endtask

    task automatic test_lr_sc_pass();
        op(64'h3000, 2'd3, OP_LR, 5'd6); tick();
        checks++; if (bus.resValid_o !== 1'b1 || bus.isLR_o !== 1'b1 || bus.scFail_o !== 1'b0) begin errors++; $display("FAIL lr_set: got res=%b lr=%b scf=%b want 1/1/0", bus.resValid_o, bus.isLR_o, bus.scFail_o); end
        idle(); repeat (9) tick();
        checks++; if (bus.resValid_o !== 1'b1) begin errors++; $display("FAIL lr_hold: got %b want 1", bus.resValid_o); end
        op(64'h3004, 2'd2, OP_SC, 5'd7); tick();
        checks++; if (bus.scFail_o !== 1'b0 || bus.isSC_o !== 1'b1) begin errors++; $display("FAIL sc_pass: got scf=%b sc=%b want 0/1", bus.scFail_o, bus.isSC_o); end
        checks++; if (bus.resValid_o !== 1'b0) begin errors++; $display("FAIL sc_clears_res: got %b want 0", bus.resValid_o); end
        op(64'h3000, 2'd3, OP_SC, 5'd8); tick();
        checks++; if (bus.scFail_o !== 1'b1) begin errors++; $display("FAIL sc_second: got %b want 1", bus.scFail_o); end
        idle(); tick();
    endtask

    task automatic test_snoop();
        op(64'h3000, 2'd3, OP_LR, 5'd9); tick();
        idle(); snoop(64'h3006); tick();
        checks++; if (bus.resValid_o !== 1'b0) begin errors++; $display("FAIL snoop_kill: got %b want 0", bus.resValid_o); end
        idle(); op(64'h3000, 2'd3, OP_SC, 5'd9); tick();
        checks++; if (bus.scFail_o !== 1'b1) begin errors++; $display("FAIL snoop_sc: got %b want 1", bus.scFail_o); end
        idle(); op(64'h3000, 2'd3, OP_LR, 5'd9); tick();
        idle(); snoop(64'h3010); tick();
        checks++; if (bus.resValid_o !== 1'b1) begin errors++; $display("FAIL snoop_other_granule: got %b want 1", bus.resValid_o); end
        idle(); op(64'h3000, 2'd3, OP_SC, 5'd9); tick();
        checks++; if (bus.scFail_o !== 1'b0) begin errors++; $display("FAIL snoop_other_sc: got %b want 0", bus.scFail_o); end
        idle(); tick();
    endtask

    task automatic test_timeout();
        op(64'h3000, 2'd3, OP_LR, 5'd10); tick();
        idle(); repeat (63) tick();
        checks++; if (bus.resValid_o !== 1'b1) begin errors++; $display("FAIL timeout_63: got %b want 1", bus.resValid_o); end
        tick();
        checks++; if (bus.resValid_o !== 1'b0) begin errors++; $display("FAIL timeout_64: got %b want 0", bus.resValid_o); end
        op(64'h3000, 2'd3, OP_SC, 5'd10); tick();
        checks++; if (bus.scFail_o !== 1'b1) begin errors++; $display("FAIL timeout_sc: got %b want 1", bus.scFail_o); end
        op(64'h3000, 2'd3, OP_LR, 5'd11); tick();
        idle(); repeat (62) tick();
        op(64'h3000, 2'd3, OP_SC, 5'd11); tick();
        checks++; if (bus.scFail_o !== 1'b0) begin errors++; $display("FAIL timeout_sc_last_ok: got %b want 0", bus.scFail_o); end
        op(64'h3000, 2'd3, OP_LR, 5'd12); tick();
        idle(); repeat (63) tick();
        op(64'h3000, 2'd3, OP_SC, 5'd12); tick();
        checks++; if (bus.scFail_o !== 1'b1) begin errors++; $display("FAIL timeout_sc_same_cycle: got %b want 1", bus.scFail_o); end
        idle(); tick();
    endtask

    task automatic test_back_to_back();
        idle(); bus.ready_i = 1'b0;
        op(64'h4000, 2'd3, OP_LD, 5'd10); tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.tag_o !== 5'd10 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_first: got v=%b tag=%0d rdy=%b want 1/10/0", bus.valid_o, bus.tag_o, bus.ready_o); end
        op(64'h4008, 2'd3, OP_ST, 5'd11);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.valid_o !== 1'b1 || bus.tag_o !== 5'd10 || bus.address_o !== 64'h4000 || bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got v=%b tag=%0d addr=%h rdy=%b want 1/10/4000/0", i, bus.valid_o, bus.tag_o, bus.address_o, bus.ready_o); end
        end
        bus.ready_i = 1'b1; #1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.ready_o); end
        tick();
        checks++; if (bus.tag_o !== 5'd11 || bus.address_o !== 64'h4008 || bus.isStore_o !== 1'b1) begin errors++; $display("FAIL b2b_op2: got tag=%0d addr=%h want 11/4008", bus.tag_o, bus.address_o); end
        op(64'h4010, 2'd2, OP_LD, 5'd12); tick();
        checks++; if (bus.tag_o !== 5'd12 || bus.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_op3: got tag=%0d v=%b want 12/1", bus.tag_o, bus.valid_o); end
        op(64'h4014, 2'd2, OP_ST, 5'd13); tick();
        checks++; if (bus.tag_o !== 5'd13 || bus.byteEn_o !== 8'hF0) begin errors++; $display("FAIL b2b_op4: got tag=%0d be=%h want 13/f0", bus.tag_o, bus.byteEn_o); end
        idle(); tick();
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.valid_o); end
    endtask

    task automatic test_simultaneous();
        op(64'h3000, 2'd3, OP_LR, 5'd14); tick();
        op(64'h4000, 2'd3, OP_LR, 5'd15); bus.flush_i = 1'b1; tick();
        checks++; if (bus.valid_o !== 1'b0 || bus.resValid_o !== 1'b0) begin errors++; $display("FAIL flush_lr: got v=%b res=%b want 0/0", bus.valid_o, bus.resValid_o); end
        idle(); op(64'h3000, 2'd3, OP_LR, 5'd16); snoop(64'h3000); tick();
        checks++; if (bus.resValid_o !== 1'b1 || bus.valid_o !== 1'b1) begin errors++; $display("FAIL lr_snoop: got res=%b v=%b want 1/1", bus.resValid_o, bus.valid_o); end
        idle(); op(64'h3000, 2'd3, OP_SC, 5'd17); snoop(64'h3002); tick();
        checks++; if (bus.scFail_o !== 1'b1 || bus.resValid_o !== 1'b0) begin errors++; $display("FAIL sc_snoop: got scf=%b res=%b want 1/0", bus.scFail_o, bus.resValid_o); end
        idle(); tick();
    endtask

    task automatic test_misaligned_sc();
        op(64'h5000, 2'd3, OP_LR, 5'd18); tick();
        op(64'h5002, 2'd2, OP_SC, 5'd18); tick();
        checks++; if (bus.scFail_o !== 1'b1 || bus.misaligned_o !== 1'b1 || bus.resValid_o !== 1'b1) begin errors++; $display("FAIL misaligned_sc: got scf=%b mis=%b res=%b want 1/1/1", bus.scFail_o, bus.misaligned_o, bus.resValid_o); end
        op(64'h5000, 2'd3, OP_ST, 5'd19); tick();
        checks++; if (bus.resValid_o !== 1'b1 || bus.scFail_o !== 1'b0) begin errors++; $display("FAIL store_keeps_res: got res=%b scf=%b want 1/0", bus.resValid_o, bus.scFail_o); end
        op(64'h5000, 2'd3, OP_SC, 5'd19); tick();
        checks++; if (bus.scFail_o !== 1'b0 || bus.resValid_o !== 1'b0) begin errors++; $display("FAIL aligned_sc_after: got scf=%b res=%b want 0/0", bus.scFail_o, bus.resValid_o); end
        idle(); tick();
    endtask

    task automatic test_reset_midstream();
        idle(); bus.ready_i = 1'b0;
        op(64'h6000, 2'd3, OP_LR, 5'd20); tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.resValid_o !== 1'b1) begin errors++; $display("FAIL pre_reset: got v=%b res=%b want 1/1", bus.valid_o, bus.resValid_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0 || bus.resValid_o !== 1'b0 || bus.isLR_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got v=%b res=%b lr=%b want 0/0/0", bus.valid_o, bus.resValid_o, bus.isLR_o); end
        checks++; if (bus.tag_o !== 5'd0 || bus.address_o !== 64'h0 || bus.byteEn_o !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got tag=%0d addr=%h be=%h want 0/0/00", bus.tag_o, bus.address_o, bus.byteEn_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(); op(64'h6008, 2'd2, OP_LD, 5'd21); tick();
        checks++; if (bus.valid_o !== 1'b1 || bus.tag_o !== 5'd21 || bus.byteEn_o !== 8'h0F || bus.resValid_o !== 1'b0) begin errors++; $display("FAIL post_reset: got v=%b tag=%0d be=%h res=%b want 1/21/0f/0", bus.valid_o, bus.tag_o, bus.byteEn_o, bus.resValid_o); end
        idle(); tick();
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_lr_sc_pass();
        test_snoop();
        test_timeout();
        test_back_to_back();
        test_simultaneous();
        test_misaligned_sc();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/agen_lsu_stage.md
# agen_lsu_stage

Registered pipeline stage directly downstream of the address-generation ALU in the load/store lane. It captures the generated address, access size and op class, then computes byte enables and a misalignment flag. It also owns the hart's LR/SC reservation (state, granule address, timeout) and resolves SC pass/fail before the op is handed to the load/store queue. Valid/ready handshake on both sides, latency of one cycle.

## Interface
- `DATA_W`, 64, address width (equals `SIZE_DATA`)
- `TAG_W`, 5, LSQ tag width carried alongside the op
- `RES_GRAN_LOG`, 3, log2 of reservation granule in bytes
- `RES_TIMEOUT`, 64, cycles a reservation survives without a matching SC
- `clk` input 1: clock; all state on the rising edge
- `reset` input 1: asynchronous, active-low reset
- `flush_i` input 1: squash; kills held output and reservation
- `valid_i` input 1: AGEN result valid
- `ready_o` output 1: stage can accept this cycle
- `address_i` input DATA_W: generated effective address
- `ldstSize_i` input 2: 0=byte, 1=half, 2=word, 3=double
- `isLoad_i`, `isStore_i`, `isLR_i`, `isSC_i` input 1 each: op class, at most one set
- `tag_i` input TAG_W: LSQ tag
- `snoopValid_i` input 1: external store/invalidation observed
- `snoopAddr_i` input DATA_W: address of that store
- `valid_o` output 1: registered op valid
- `ready_i` input 1: LSQ accepts
- `address_o` output DATA_W, `ldstSize_o` output 2, `tag_o` output TAG_W, `isLoad_o`/`isStore_o`/`isLR_o`/`isSC_o` output 1: registered copies
- `byteEn_o` output 8: byte lanes within the doubleword
- `misaligned_o` output 1: address not naturally aligned to size
- `scFail_o` output 1: SC must not write; returns 1 to rd
- `resValid_o` output 1: reservation currently held

## Operation
- `ready_o = !valid_o || ready_i` (combinational). Accept when `valid_i && ready_o && !flush_i`.
- On accept, register all pass-through fields. Then:
  - `misaligned = (address_i & ((1<<size)-1)) != 0`.
  - `byteEn = misaligned ? 0 : (((1<<(1<<size))-1) << address_i[2:0])`, truncated to 8 bits.
- If `ready_i` is high with no accept, clear `valid_o`. Data fields hold their last value.
- Reservation FSM has two states: RES_IDLE and RES_HELD. It uses a granule register `resAddr = addr[DATA_W-1:RES_GRAN_LOG]` and a counter `resCnt`.
  - Accepted aligned LR: go to RES_HELD, load `resAddr`, clear `resCnt`. This applies from either state.
  - Accepted aligned SC: `scFail = !(HELD && granule match)`. The next state is RES_IDLE.
  - Accepted misaligned LR or SC: `scFail = 1` for SC. The reservation state is untouched.
  - Snoop while HELD with a matching granule: go to RES_IDLE.
  - While HELD, `resCnt` increments each cycle. At `RES_TIMEOUT-1` the FSM goes to RES_IDLE.
  - Plain loads and stores from this stage never affect the reservation.
- `scFail_o` is 0 for any non-SC op.

## Timing
- Latency is one cycle: an op accepted in cycle N is visible on the outputs in cycle N+1.
- Throughput is one op per cycle while `ready_i` is held high.
- Reset (async assert) clears:
  - `valid_o`, `byteEn_o`, `misaligned_o`, `scFail_o`, `resValid_o`, `address_o`, `ldstSize_o` and `tag_o` to 0, along with all `is*_o`.
  - The FSM to RES_IDLE and `resCnt` to 0.
- Reset release is synchronous to `clk` at the instance boundary.
- `flush_i` (synchronous, highest priority):
  - next `valid_o = 0`, with no accept that cycle;
  - FSM goes to RES_IDLE and `resCnt` to 0.
- Same-cycle priority:
  - flush beats everything;
  - accepted LR beats a matching snoop and the timeout, so the new reservation is set;
  - an SC accepted in the same cycle as a matching snoop fails;
  - an SC accepted in the timeout cycle fails.
- The SC comparison uses the reservation state at the start of the cycle, with same-cycle snoop and timeout applied as above.
- Stall: while `valid_o && !ready_i`, all outputs hold stable and `ready_o = 0`. Reservation snoops and the timeout are still processed.
- `resValid_o` is registered and equals (state == RES_HELD).

## Test plan
- Reset mid-stream: assert `reset` low with `valid_o=1`. Outputs go to 0 immediately, FSM to IDLE; first accept after release passes normally.
- Alignment: word at 0x1004 -> `byteEn_o=0xF0`, `misaligned_o=0`. Half at 0x1003 -> `byteEn_o=0x00`, `misaligned_o=1`. Double at 0x2000 -> `0xFF`.
- LR/SC pass: LR 0x3000, then SC 0x3004 10 cycles later -> `scFail_o=0`, `resValid_o` 1 then 0. A second SC to 0x3000 -> `scFail_o=1`.
- Snoop and timeout: LR 0x3000, snoop 0x3006 -> `resValid_o=0`, later SC fails. Separately, LR then idle 64 cycles -> `resValid_o` drops on cycle 64, SC fails.
- Backpressure: `ready_i=0` for 5 cycles with `valid_i=1` -> `ready_o=0`, outputs stable, no op lost or duplicated. Four back-to-back ops then emerge in order with their tags.
- Simultaneous: flush in the same cycle as an LR -> no accept, `resValid_o=0`. LR in the same cycle as a matching snoop -> `resValid_o=1`.
